// File: rtl/sdm_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdm_mon_pkg
// Brief    : Shared widths, state encoding and sizing helpers for the
//            sinc3 window monitor.
// Revision : 1.0  initial release
// ============================================================================
package sdm_mon_pkg;

    localparam int SAMPLE_W     = 16;
    // Trip counters hold values up to 255.
    localparam int TRIP_W       = 8;
    // Watchdog counter width for the default timeout of 4096 cycles.
    localparam int WD_W_DEFAULT = $clog2(4096 + 1);

    typedef enum logic [0:0] {
        TRIP_OK      = 1'b0,
        TRIP_TRIPPED = 1'b1
    } trip_state_t;

    // Accumulator wide enough to hold 2^avg_log2 full-scale samples.
    function automatic int acc_width(input int avg_log2);
        return SAMPLE_W + avg_log2;
    endfunction

    // Counter width able to represent the terminal value itself.
    function automatic int wd_width(input int timeout_cycles);
        return $clog2(timeout_cycles + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdm_trip_fsm.sv
`default_nettype none
// ============================================================================
// Module   : sdm_trip_fsm
// Brief    : Saturating consecutive-violation counter feeding a sticky
//            OK/TRIPPED fault state machine (one per threshold direction).
// Revision : 1.0  initial release
// ============================================================================
module sdm_trip_fsm
    import sdm_mon_pkg::*;
#(
    parameter int TRIP_COUNT = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic out_of_window,
    input  logic din_valid,
    input  logic fault_clr,
    output logic fault
);

    localparam logic [TRIP_W-1:0] c_trip_max = TRIP_W'(TRIP_COUNT);

    trip_state_t       r_state;
    trip_state_t       w_state_nx;
    logic [TRIP_W-1:0] r_cnt;
    logic [TRIP_W-1:0] w_cnt_nx;
    logic [TRIP_W-1:0] w_cnt_inc;
    logic              w_trip;

    // Next-state: a completing violation beats a simultaneous clear.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_cnt_inc  = (r_cnt == c_trip_max) ? c_trip_max : r_cnt + 1'b1;
        w_trip     = din_valid && out_of_window && (w_cnt_inc == c_trip_max);

        if (din_valid) begin
            w_cnt_nx = out_of_window ? w_cnt_inc : '0;
        end

        if (w_trip) begin
            w_state_nx = TRIP_TRIPPED;
        end else if (fault_clr && (r_state == TRIP_TRIPPED)) begin
            w_state_nx = TRIP_OK;
            w_cnt_nx   = '0;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= TRIP_OK;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    assign fault = (r_state == TRIP_TRIPPED);

endmodule
`default_nettype wire

// File: rtl/sdm_window_monitor.sv
`default_nettype none
// ============================================================================
// Module   : sdm_window_monitor
// Brief    : Block averager, debounced window fault flags and stale-data
//            watchdog for the sinc3 decimator output stream.
// Revision : 1.0  initial release
// ============================================================================
module sdm_window_monitor
    import sdm_mon_pkg::*;
#(
    parameter int AVG_LOG2       = 4,
    parameter int TRIP_COUNT     = 3,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                mclk1,
    input  logic                reset_n,
    input  logic [SAMPLE_W-1:0] din,
    input  logic                din_valid,
    input  logic [SAMPLE_W-1:0] thr_hi,
    input  logic [SAMPLE_W-1:0] thr_lo,
    input  logic                fault_clr,
    output logic [SAMPLE_W-1:0] avg_out,
    output logic                avg_valid,
    output logic                fault_hi,
    output logic                fault_lo,
    output logic                stale
);

    localparam int c_acc_w = acc_width(AVG_LOG2);
    localparam int c_wd_w  = wd_width(TIMEOUT_CYCLES);
    localparam logic [c_wd_w-1:0] c_wd_max = c_wd_w'(TIMEOUT_CYCLES);

    logic [SAMPLE_W-1:0] r_avg_out;
    logic                r_avg_valid;
    logic [c_wd_w-1:0]   r_wd_cnt;
    logic [c_wd_w-1:0]   w_wd_nx;
    logic                r_stale;
    logic                w_over;
    logic                w_under;

    // ------------------------------------------------------------------
    // Block averaging
    // ------------------------------------------------------------------
    generate
        if (AVG_LOG2 == 0) begin : g_passthru
            // One-sample blocks: every accepted sample is its own average.
            always_ff @(posedge mclk1) begin
                if (!reset_n) begin
                    r_avg_out   <= '0;
                    r_avg_valid <= 1'b0;
                end else begin
                    r_avg_valid <= din_valid;
                    if (din_valid) begin
                        r_avg_out <= din;
                    end
                end
            end
        end else begin : g_block
            logic [c_acc_w-1:0]  r_acc;
            logic [AVG_LOG2-1:0] r_cnt;
            logic [c_acc_w-1:0]  w_sum;

            assign w_sum = r_acc + {{AVG_LOG2{1'b0}}, din};

            // Accumulate; on the closing sample publish the truncated mean.
            always_ff @(posedge mclk1) begin
                if (!reset_n) begin
                    r_acc       <= '0;
                    r_cnt       <= '0;
                    r_avg_out   <= '0;
                    r_avg_valid <= 1'b0;
                end else begin
                    r_avg_valid <= 1'b0;
                    if (din_valid) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (&r_cnt) begin
                            r_avg_out   <= w_sum[c_acc_w-1:AVG_LOG2];
                            r_avg_valid <= 1'b1;
                            r_acc       <= '0;
                        end else begin
                            r_acc <= w_sum;
                        end
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Window fault detection; equality with a threshold is in-window
    // ------------------------------------------------------------------
    assign w_over  = (din > thr_hi);
    assign w_under = (din < thr_lo);

    sdm_trip_fsm #(
        .TRIP_COUNT    (TRIP_COUNT)
    ) u_trip_hi (
        .clk           (mclk1),
        .reset_n       (reset_n),
        .out_of_window (w_over),
        .din_valid     (din_valid),
        .fault_clr     (fault_clr),
        .fault         (fault_hi)
    );

    sdm_trip_fsm #(
        .TRIP_COUNT    (TRIP_COUNT)
    ) u_trip_lo (
        .clk           (mclk1),
        .reset_n       (reset_n),
        .out_of_window (w_under),
        .din_valid     (din_valid),
        .fault_clr     (fault_clr),
        .fault         (fault_lo)
    );

    // ------------------------------------------------------------------
    // Stale-data watchdog
    // ------------------------------------------------------------------
    // Idle-cycle count, saturating at the timeout.
    always_comb begin
        w_wd_nx = r_wd_cnt;
        if (din_valid) begin
            w_wd_nx = '0;
        end else if (r_wd_cnt != c_wd_max) begin
            w_wd_nx = r_wd_cnt + 1'b1;
        end
    end

    // stale tracks the saturated count on the same edge it is reached.
    always_ff @(posedge mclk1) begin
        if (!reset_n) begin
            r_wd_cnt <= '0;
            r_stale  <= 1'b0;
        end else begin
            r_wd_cnt <= w_wd_nx;
            r_stale  <= (w_wd_nx == c_wd_max);
        end
    end

    assign avg_out   = r_avg_out;
    assign avg_valid = r_avg_valid;
    assign stale     = r_stale;

endmodule
`default_nettype wire

// File: tb/tb_sdm_window_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdm_window_monitor
// Brief    : Self-checking bench: two differently parameterised monitors
//            driven from shared stimulus, compared each cycle against a
//            behavioural model, plus directed boundary checks.
// Revision : 1.0  initial release
// ============================================================================
module tb_sdm_window_monitor;

    logic        mclk1;
    logic        reset_n;
    logic [15:0] din;
    logic        din_valid;
    logic [15:0] thr_hi;
    logic [15:0] thr_lo;
    logic        fault_clr;

    logic [15:0] avg_out_a, avg_out_b;
    logic        avg_valid_a, avg_valid_b;
    logic        fault_hi_a, fault_hi_b;
    logic        fault_lo_a, fault_lo_b;
    logic        stale_a, stale_b;

    // Instance A: 4-sample blocks, 3-sample debounce, 8-cycle timeout.
    sdm_window_monitor #(
        .AVG_LOG2       (2),
        .TRIP_COUNT     (3),
        .TIMEOUT_CYCLES (8)
    ) u_dut_a (
        .mclk1     (mclk1),
        .reset_n   (reset_n),
        .din       (din),
        .din_valid (din_valid),
        .thr_hi    (thr_hi),
        .thr_lo    (thr_lo),
        .fault_clr (fault_clr),
        .avg_out   (avg_out_a),
        .avg_valid (avg_valid_a),
        .fault_hi  (fault_hi_a),
        .fault_lo  (fault_lo_a),
        .stale     (stale_a)
    );

    // Instance B: 16-sample blocks, single-sample trip, 20-cycle timeout.
    sdm_window_monitor #(
        .AVG_LOG2       (4),
        .TRIP_COUNT     (1),
        .TIMEOUT_CYCLES (20)
    ) u_dut_b (
        .mclk1     (mclk1),
        .reset_n   (reset_n),
        .din       (din),
        .din_valid (din_valid),
        .thr_hi    (thr_hi),
        .thr_lo    (thr_lo),
        .fault_clr (fault_clr),
        .avg_out   (avg_out_b),
        .avg_valid (avg_valid_b),
        .fault_hi  (fault_hi_b),
        .fault_lo  (fault_lo_b),
        .stale     (stale_b)
    );

    initial mclk1 = 1'b0;
    always #5 mclk1 = ~mclk1;

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural reference model (index 0 = A, 1 = B)
    // ------------------------------------------------------------------
    int p_al[2] = '{2, 4};
    int p_tc[2] = '{3, 1};
    int p_to[2] = '{8, 20};

    int          m_sum[2];
    int          m_n[2];
    int          m_run_hi[2];
    int          m_run_lo[2];
    int          m_idle[2];
    logic [15:0] m_avg[2];
    bit          m_av[2];
    bit          m_fhi[2];
    bit          m_flo[2];
    bit          m_stale[2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_sum[k] = 0; m_n[k] = 0; m_run_hi[k] = 0; m_run_lo[k] = 0;
            m_idle[k] = 0; m_avg[k] = '0; m_av[k] = 0; m_fhi[k] = 0;
            m_flo[k] = 0; m_stale[k] = 0;
        end
    end

    // Run length of consecutive violations; trips once it reaches tc.
    task automatic dir_step(input int tc, input bit hit, input int run_in, input bit flag_in,
                            output int run_out, output bit flag_out);
        int run;
        bit flag;
        bit trip;
        run  = run_in;
        flag = flag_in;
        if (din_valid) run = hit ? run + 1 : 0;
        trip = din_valid && hit && (run >= tc);
        if (trip) begin
            flag = 1;
        end else if (fault_clr && flag) begin
            flag = 0;
            run  = 0;
        end
        run_out  = run;
        flag_out = flag;
    endtask

    task automatic model_step(input int k);
        int r;
        bit f;
        if (!reset_n) begin
            m_sum[k] = 0; m_n[k] = 0; m_run_hi[k] = 0; m_run_lo[k] = 0;
            m_idle[k] = 0; m_avg[k] = '0; m_av[k] = 0; m_fhi[k] = 0;
            m_flo[k] = 0; m_stale[k] = 0;
            return;
        end
        m_av[k] = 0;
        if (din_valid) begin
            m_sum[k] += int'(din);
            m_n[k]++;
            if (m_n[k] == (1 << p_al[k])) begin
                m_avg[k] = 16'(m_sum[k] / (1 << p_al[k]));
                m_av[k]  = 1;
                m_sum[k] = 0;
                m_n[k]   = 0;
            end
        end
        dir_step(p_tc[k], din > thr_hi, m_run_hi[k], m_fhi[k], r, f);
        m_run_hi[k] = r; m_fhi[k] = f;
        dir_step(p_tc[k], din < thr_lo, m_run_lo[k], m_flo[k], r, f);
        m_run_lo[k] = r; m_flo[k] = f;
        m_idle[k]  = din_valid ? 0 : m_idle[k] + 1;
        m_stale[k] = (m_idle[k] >= p_to[k]);
    endtask

    task automatic compare_all();
        check("a_avg_valid", 32'(avg_valid_a), 32'(m_av[0]));
        check("a_avg_out",   32'(avg_out_a),   32'(m_avg[0]));
        check("a_fault_hi",  32'(fault_hi_a),  32'(m_fhi[0]));
        check("a_fault_lo",  32'(fault_lo_a),  32'(m_flo[0]));
        check("a_stale",     32'(stale_a),     32'(m_stale[0]));
        check("b_avg_valid", 32'(avg_valid_b), 32'(m_av[1]));
        check("b_avg_out",   32'(avg_out_b),   32'(m_avg[1]));
        check("b_fault_hi",  32'(fault_hi_b),  32'(m_fhi[1]));
        check("b_fault_lo",  32'(fault_lo_b),  32'(m_flo[1]));
        check("b_stale",     32'(stale_b),     32'(m_stale[1]));
    endtask

    // One clock: model consumes the inputs the DUT samples, then compare.
    task automatic tick();
        @(posedge mclk1);
        model_step(0);
        model_step(1);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        fault_clr = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [15:0] d, input logic clr);
        din       = d;
        din_valid = 1'b1;
        fault_clr = clr;
        tick();
        din_valid = 1'b0;
        fault_clr = 1'b0;
    endtask

    task automatic pulse_reset();
        din_valid = 1'b0;
        fault_clr = 1'b0;
        reset_n   = 1'b0;
        tick();
        reset_n   = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int quiet;
        reset_n   = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        thr_hi    = 16'hFFFF;
        thr_lo    = 16'h0000;
        fault_clr = 1'b0;
        quiet     = 0;

        tick();
        tick();
        check("rst_avg_out",  32'(avg_out_a),  32'h0);
        check("rst_fault_hi", 32'(fault_hi_a), 32'h0);
        check("rst_stale",    32'(stale_a),    32'h0);
        reset_n = 1'b1;

        // Watchdog from reset release.
        idle(7);
        check("stale_before_timeout", 32'(stale_a), 32'h0);
        idle(1);
        check("stale_at_timeout", 32'(stale_a), 32'h1);
        idle(14);
        check("stale_b_at_timeout", 32'(stale_b), 32'h1);

        // Block of four with gaps; first sample also clears stale.
        send(16'h0010, 1'b0);
        check("stale_cleared", 32'(stale_a), 32'h0);
        idle(2);
        send(16'h0020, 1'b0);
        idle(1);
        send(16'h0030, 1'b0);
        check("avg_no_early_valid", 32'(avg_valid_a), 32'h0);
        idle(3);
        send(16'h0041, 1'b0);
        check("avg_valid_4th", 32'(avg_valid_a), 32'h1);
        check("avg_028",       32'(avg_out_a),   32'h0028);
        idle(1);
        check("avg_valid_single", 32'(avg_valid_a), 32'h0);

        // Partial block discarded by a mid-block reset.
        pulse_reset();
        send(16'h0100, 1'b0);
        send(16'h0100, 1'b0);
        idle(1);
        send(16'h0100, 1'b0);
        pulse_reset();
        check("post_rst_fault_hi", 32'(fault_hi_a), 32'h0);
        check("post_rst_stale",    32'(stale_a),    32'h0);
        for (int i = 0; i < 4; i++) begin
            send(16'h0004, 1'b0);
            idle(1);
        end
        check("avg_after_reset", 32'(avg_out_a), 32'h0004);

        // Full-scale block on B, then an all-zero block.
        pulse_reset();
        for (int i = 0; i < 16; i++) send(16'hFFFF, 1'b0);
        check("avg_b_full_valid", 32'(avg_valid_b), 32'h1);
        check("avg_b_full",       32'(avg_out_b),   32'hFFFF);
        for (int i = 0; i < 16; i++) send(16'h0000, 1'b0);
        check("avg_b_zero", 32'(avg_out_b), 32'h0000);

        // Debounced over-threshold with an equality sample in the run.
        thr_hi = 16'h8000;
        send(16'h8001, 1'b0);
        send(16'h8001, 1'b0);
        send(16'h8000, 1'b0);
        send(16'h8001, 1'b0);
        send(16'h8001, 1'b0);
        check("hi_not_yet", 32'(fault_hi_a), 32'h0);
        send(16'h8001, 1'b0);
        check("hi_tripped", 32'(fault_hi_a), 32'h1);

        // Clear colliding with a trip-completing sample loses.
        send(16'h8000, 1'b0);
        send(16'h8001, 1'b0);
        send(16'h8001, 1'b0);
        send(16'h8001, 1'b1);
        check("hi_trip_beats_clr", 32'(fault_hi_a), 32'h1);
        idle(2);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check("hi_cleared", 32'(fault_hi_a), 32'h0);

        // Under-threshold direction, equality in-window.
        thr_hi = 16'hFFFF;
        thr_lo = 16'h0100;
        send(16'h00FF, 1'b0);
        send(16'h00FF, 1'b0);
        send(16'h0100, 1'b0);
        check("lo_eq_in_window", 32'(fault_lo_a), 32'h0);
        for (int i = 0; i < 3; i++) send(16'h00FF, 1'b0);
        check("lo_tripped", 32'(fault_lo_a), 32'h1);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;

        // Randomised traffic.
        thr_hi = 16'hC000;
        thr_lo = 16'h4000;
        for (int i = 0; i < 3000; i++) begin
            reset_n = ($urandom_range(0, 599) != 0);
            if ($urandom_range(0, 299) == 0) begin
                thr_hi = 16'($urandom);
                thr_lo = 16'($urandom);
            end
            if (quiet == 0 && $urandom_range(0, 150) == 0) quiet = $urandom_range(5, 30);
            if (quiet > 0) begin
                din_valid = 1'b0;
                quiet--;
            end else begin
                din_valid = ($urandom_range(0, 2) != 0);
            end
            case ($urandom_range(0, 5))
                0:       din = thr_hi + 16'($urandom_range(0, 2)) - 16'd1;
                1:       din = thr_lo + 16'($urandom_range(0, 2)) - 16'd1;
                2:       din = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0000;
                3:       din = thr_hi + 16'd5;
                default: din = 16'($urandom);
            endcase
            fault_clr = ($urandom_range(0, 11) == 0);
            tick();
        end
        reset_n   = 1'b1;
        din_valid = 1'b0;
        fault_clr = 1'b0;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdm_window_monitor.md
Name: sdm_window_monitor

Overview:
- Sits directly downstream of the sinc3 decimator and consumes its 16-bit unsigned sample word and one-cycle data-valid strobe.
- Produces a block-averaged output word and debounced over/under-threshold fault flags.
- Provides a stale-data watchdog that flags when the decimator stops producing samples.
- Runs on the same modulator clock as the decimator, so no CDC is needed.

Parameters:
- AVG_LOG2, 4, log2 of samples per average block; legal range 0..8 (0 = pass-through).
- TRIP_COUNT, 3, consecutive out-of-window samples required to latch a fault; legal range 1..255.
- TIMEOUT_CYCLES, 4096, mclk1 cycles without din_valid before stale asserts; must be ≥ 2.

Ports:
- mclk1  in  1  sole clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- din  in  16  unsigned sample word from the decimator (0x0000..0xFFFF).
- din_valid  in  1  one-cycle strobe; din is sampled only when high.
- thr_hi  in  16  upper threshold, unsigned; quasi-static.
- thr_lo  in  16  lower threshold, unsigned; quasi-static.
- fault_clr  in  1  one-cycle request to clear both fault flags.
- avg_out  out  16  last completed block average.
- avg_valid  out  1  one-cycle pulse when avg_out updates.
- fault_hi  out  1  sticky over-threshold fault.
- fault_lo  out  1  sticky under-threshold fault.
- stale  out  1  no sample seen for TIMEOUT_CYCLES.

Behaviour:
- Reset (reset_n low at a rising edge):
  - Outputs: avg_out=0, avg_valid=0, fault_hi=0, fault_lo=0, stale=0.
  - Internal: accumulator, sample counter, trip counters and watchdog counter all cleared.
  - An average block in progress is discarded; no partial result is emitted.
- Averaging:
  - Accumulator is 16+AVG_LOG2 bits wide, unsigned, and cannot overflow.
  - Each din_valid adds din and increments the sample counter (AVG_LOG2 bits, wraps).
  - On the accepted sample with counter == 2^AVG_LOG2-1:
    - next edge: avg_out = (acc+din) >> AVG_LOG2 (truncate), avg_valid=1;
    - the accumulator restarts at 0.
  - Latency: avg_valid is high exactly one cycle after the closing din_valid.
  - avg_valid is never high two cycles in a row unless AVG_LOG2=0 and din_valid is back-to-back.
- Trip counters (hi and lo are independent):
  - On din_valid with din > thr_hi, hi_cnt increments, saturating at TRIP_COUNT; on din_valid with din ≤ thr_hi, hi_cnt clears.
  - lo_cnt works the same way with din < thr_lo.
  - Equality with a threshold is in-window.
  - Cycles without din_valid leave both counters unchanged.
- Fault FSM, one per direction:
  - States: OK, TRIPPED.
  - OK→TRIPPED on the edge where the counter reaches TRIP_COUNT; the fault flag goes high that same edge (flag = state==TRIPPED).
  - TRIPPED→OK on fault_clr, and the trip counter is cleared.
  - If fault_clr coincides with a trip-completing sample, the trip wins: the state stays or enters TRIPPED.
  - fault_clr has no effect in OK.
  - thr_lo > thr_hi is not rejected: both faults may latch.
- Watchdog:
  - The counter clears on din_valid and otherwise increments, saturating at TIMEOUT_CYCLES.
  - stale goes high on the edge where the counter reaches TIMEOUT_CYCLES.
  - stale returns low on the edge following the next din_valid.
  - Immediately after reset the watchdog runs, so stale asserts if no sample ever arrives.
- All outputs are registered; there are no combinational input→output paths.

Decomposition:
- Package sdm_mon_pkg:
  - SAMPLE_W=16;
  - function acc_width(avg_log2);
  - localparam for watchdog counter width = $clog2(TIMEOUT_CYCLES+1).
- Sub-module sdm_trip_fsm, instantiated twice (hi, lo):
  - contents: saturating trip counter plus OK/TRIPPED FSM;
  - inputs: compare-result, din_valid, fault_clr;
  - output: fault flag.

Test Plan:
- AVG_LOG2=2, samples 0x0010,0x0020,0x0030,0x0041 with gaps: avg_out=0x0028 and avg_valid one cycle after the 4th strobe only.
- AVG_LOG2=4, 16 samples of 0xFFFF: avg_out=0xFFFF, no overflow; the next block of 16×0x0000 gives 0x0000.
- thr_hi=0x8000, TRIP_COUNT=3, samples 0x8001,0x8001,0x8000,0x8001,0x8001,0x8001:
  - fault_hi stays low through the 5th sample;
  - fault_hi rises on the edge of the 6th strobe;
  - a sample of exactly 0x8000 resets the count.
- fault_hi latched, pulse fault_clr on the same cycle as a 3rd consecutive out-of-window din_valid: fault_hi remains 1; an isolated fault_clr later drops it next edge.
- TIMEOUT_CYCLES=8, no din_valid after reset: stale rises 8 cycles after reset release; one din_valid drops stale the following edge.
- Mid-block reset: 3 of 4 samples accepted, then reset_n low 1 cycle, then 4 samples of 0x0004: a single avg_valid with avg_out=0x0004; faults and stale read 0 after reset.
